// File: rtl/fp_pkg.sv
// Shared types and constants for the FP normalize/pack stage.
// Covers the FSM state type, working-exponent width and the IEEE single-precision field layout.
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    PACK = 2'd2,
    DONE = 2'd3
  } state_t;

  // Working exponent spans -23..256, so 10 bits signed never wraps.
  localparam int WEXP_W      = 10;
  localparam int EXP_MAX     = 255;
  localparam int FRAC_W      = 23;
  localparam int EXP_FIELD_W = 8;
  localparam int SIGN_BIT    = 31;
  localparam int EXP_MSB     = 30;
  localparam int EXP_LSB     = 23;

  localparam logic [31:0] INF_WORD = 32'h7F800000;

endpackage

// File: rtl/fp_norm_pack_if.sv
// Upstream/downstream handshake bundle for fp_norm_pack.
// A transfer happens on a rising edge where valid and ready are both high; valid never depends on ready.
interface fp_norm_pack_if #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [MANT_W-1:0] mant_in;
  logic              carry_in;
  logic [EXP_W-1:0]  exp_in;
  logic              sign_in;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       result;
  logic              flag_zero;
  logic              flag_ovf;
  logic              flag_udf;

  modport master (
    output in_valid, mant_in, carry_in, exp_in, sign_in, out_ready,
    input  in_ready, out_valid, result, flag_zero, flag_ovf, flag_udf
  );

  modport slave (
    input  in_valid, mant_in, carry_in, exp_in, sign_in, out_ready,
    output in_ready, out_valid, result, flag_zero, flag_ovf, flag_udf
  );
endinterface

// File: rtl/fp_pack_word.sv
// Combinational packing of a normalized mantissa into an IEEE single word.
// Priority: exact zero, then overflow to infinity, then underflow flush, then normal pack.
module fp_pack_word
  import fp_pkg::*;
(
  input  logic                     sign,
  input  logic signed [WEXP_W-1:0] exp,
  input  logic [FRAC_W:0]          mant,
  input  logic                     zero,
  output logic [31:0]              word,
  output logic                     flag_zero,
  output logic                     flag_ovf,
  output logic                     flag_udf
);

  localparam logic signed [WEXP_W-1:0] EXP_MAX_S = WEXP_W'(EXP_MAX);
  localparam logic signed [WEXP_W-1:0] EXP_ZERO  = '0;

  always_comb begin
    word      = '0;
    flag_zero = 1'b0;
    flag_ovf  = 1'b0;
    flag_udf  = 1'b0;
    if (zero) begin
      // Exact zero is always +0, whatever the incoming sign.
      flag_zero = 1'b1;
    end else if (exp >= EXP_MAX_S) begin
      word           = INF_WORD;
      word[SIGN_BIT] = sign;
      flag_ovf       = 1'b1;
    end else if (exp <= EXP_ZERO) begin
      word[SIGN_BIT] = sign;
      flag_udf       = 1'b1;
    end else begin
      word[SIGN_BIT]        = sign;
      word[EXP_MSB:EXP_LSB] = exp[EXP_FIELD_W-1:0];
      word[FRAC_W-1:0]      = mant[FRAC_W-1:0];
    end
  end

endmodule

// File: rtl/fp_norm_pack.sv
// Normalizes the adder mantissa one bit per cycle, then packs a truncated IEEE single word.
// Single-entry stage: a new operand is taken only in IDLE, the result is held in DONE.
module fp_norm_pack
  import fp_pkg::*;
#(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  fp_norm_pack_if.slave bus,
  output state_t state_dbg
);

  state_t state_q, state_d;

  logic [MANT_W-1:0]        mant_r;
  logic                     carry_r;
  logic signed [WEXP_W-1:0] exp_r;
  logic                     sign_r;
  logic                     zero_r;
  logic [31:0]              result_r;
  logic                     flag_zero_r;
  logic                     flag_ovf_r;
  logic                     flag_udf_r;

  logic [31:0] pk_word;
  logic        pk_zero;
  logic        pk_ovf;
  logic        pk_udf;

  logic mant_is_zero;
  logic mant_msb;

  assign mant_is_zero = (mant_r == '0);
  assign mant_msb     = mant_r[MANT_W-1];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; NORM priority is carry, zero, left shift, done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.in_valid) state_d = NORM;
      NORM: begin
        if (carry_r)           state_d = NORM;
        else if (mant_is_zero) state_d = PACK;
        else if (!mant_msb)    state_d = NORM;
        else                   state_d = PACK;
      end
      PACK: state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    state_dbg     = state_q;
  end

  // Datapath follows the same priority as the next-state logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mant_r      <= '0;
      carry_r     <= 1'b0;
      exp_r       <= '0;
      sign_r      <= 1'b0;
      zero_r      <= 1'b0;
      result_r    <= '0;
      flag_zero_r <= 1'b0;
      flag_ovf_r  <= 1'b0;
      flag_udf_r  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            mant_r  <= bus.mant_in;
            carry_r <= bus.carry_in;
            exp_r   <= signed'(WEXP_W'(bus.exp_in));
            sign_r  <= bus.sign_in;
            zero_r  <= 1'b0;
          end
        end
        NORM: begin
          if (carry_r) begin
            // Carry becomes the new hidden bit; the old LSB is truncated.
            mant_r  <= {1'b1, mant_r[MANT_W-1:1]};
            exp_r   <= exp_r + WEXP_W'(1);
            carry_r <= 1'b0;
          end else if (mant_is_zero) begin
            zero_r <= 1'b1;
          end else if (!mant_msb) begin
            mant_r <= {mant_r[MANT_W-2:0], 1'b0};
            exp_r  <= exp_r - WEXP_W'(1);
          end
        end
        PACK: begin
          result_r    <= pk_word;
          flag_zero_r <= pk_zero;
          flag_ovf_r  <= pk_ovf;
          flag_udf_r  <= pk_udf;
        end
        DONE: begin
          if (bus.out_ready) begin
            flag_zero_r <= 1'b0;
            flag_ovf_r  <= 1'b0;
            flag_udf_r  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  fp_pack_word u_pack (
    .sign      (sign_r),
    .exp       (exp_r),
    .mant      (mant_r),
    .zero      (zero_r),
    .word      (pk_word),
    .flag_zero (pk_zero),
    .flag_ovf  (pk_ovf),
    .flag_udf  (pk_udf)
  );

  assign bus.result    = result_r;
  assign bus.flag_zero = flag_zero_r;
  assign bus.flag_ovf  = flag_ovf_r;
  assign bus.flag_udf  = flag_udf_r;

endmodule
